// File: rtl/avalon_reg_bank_pkg.sv
// Shared helpers for the Avalon register bank: byte-lane arithmetic and
// flattened-bus slice indexing used by the top and the register slices.
package avalon_reg_bank_pkg;

    localparam int BYTE_W = 8;

    function automatic int byte_lanes(input int data_w);
        return data_w / BYTE_W;
    endfunction

    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/avalon_reg_bank_if.sv
// Avalon-MM slave-side bus bundle for the register bank (fixed read latency, no waitrequest).
interface avalon_reg_bank_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
);
    logic                  chipselect;
    logic [ADDR_W-1:0]     address;
    logic                  read;
    logic                  write;
    logic [DATA_W/8-1:0]   byteenable;
    logic [DATA_W-1:0]     writedata;
    logic [DATA_W-1:0]     readdata;
    logic                  readdatavalid;

    modport master (
        output chipselect, address, read, write, byteenable, writedata,
        input  readdata, readdatavalid
    );

    modport slave (
        input  chipselect, address, read, write, byteenable, writedata,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/avalon_reg_slice.sv
// One read/write register with per-byte bus writes and a full-width hardware load;
// on a same-edge collision the bus owns its enabled lanes and hw_d owns the rest.
module avalon_reg_slice
    import avalon_reg_bank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                bus_we,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    input  logic                hw_we,
    input  logic [DATA_W-1:0]   hw_d,
    output logic [DATA_W-1:0]   q
);

    localparam int LANES = byte_lanes(DATA_W);

    logic [DATA_W-1:0] next_s;
    logic [DATA_W-1:0] q_r;

    // Per-lane merge of bus write, hardware load and hold.
    always_comb begin
        next_s = q_r;
        for (int k = 0; k < LANES; k++) begin
            if (bus_we && byteenable[k]) begin
                next_s[k*BYTE_W +: BYTE_W] = writedata[k*BYTE_W +: BYTE_W];
            end else if (hw_we) begin
                next_s[k*BYTE_W +: BYTE_W] = hw_d[k*BYTE_W +: BYTE_W];
            end else begin
                next_s[k*BYTE_W +: BYTE_W] = q_r[k*BYTE_W +: BYTE_W];
            end
        end
    end

    // Register storage with synchronous reset to the configured value.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_r <= RESET_VAL;
        end else begin
            q_r <= next_s;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/avalon_reg_bank.sv
// Parametrised Avalon-MM register bank: address decode, write strobes, read mux and a
// one-cycle registered read path; RW contents are exported on reg_q, RO slots read ro_in.
module avalon_reg_bank
    import avalon_reg_bank_pkg::*;
#(
    parameter int                  DATA_W    = 32,
    parameter int                  NUM_REGS  = 8,
    parameter int                  ADDR_W    = 3,
    parameter logic [NUM_REGS-1:0] RO_MASK   = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    avalon_reg_bank_if.slave             bus,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_in,
    input  logic [NUM_REGS-1:0]          hw_we,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_d,
    output logic [NUM_REGS-1:0]          wr_strobe
);

    logic [NUM_REGS-1:0] addr_dec_s;
    logic [NUM_REGS-1:0] wr_sel_s;
    logic                rd_req_s;
    logic [DATA_W-1:0]   rd_data_s;
    logic [NUM_REGS-1:0] wr_strobe_r;
    logic [DATA_W-1:0]   readdata_r;
    logic                readdatavalid_r;
    logic                unused_s;

    assign rd_req_s = bus.chipselect & bus.read;

    // One-hot word decode; addresses beyond the bank match nothing.
    always_comb begin
        addr_dec_s = '0;
        wr_sel_s   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            addr_dec_s[i] = (int'(bus.address) == i);
            wr_sel_s[i]   = bus.chipselect & bus.write & addr_dec_s[i] & ~RO_MASK[i];
        end
    end

    // Read mux: RO slots return live ro_in, RW slots the current register value.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data_s = rd_data_s | ({DATA_W{addr_dec_s[i]}} &
                        (RO_MASK[i] ? ro_in[slice_lo(i, DATA_W) +: DATA_W]
                                    : reg_q[slice_lo(i, DATA_W) +: DATA_W]));
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (RO_MASK[g]) begin : g_ro
            assign reg_q[slice_lo(g, DATA_W) +: DATA_W] = '0;
        end else begin : g_rw
            avalon_reg_slice #(
                .DATA_W    (DATA_W),
                .RESET_VAL (RESET_VAL)
            ) u_slice (
                .clock      (clock),
                .reset      (reset),
                .bus_we     (wr_sel_s[g]),
                .byteenable (bus.byteenable),
                .writedata  (bus.writedata),
                .hw_we      (hw_we[g]),
                .hw_d       (hw_d[slice_lo(g, DATA_W) +: DATA_W]),
                .q          (reg_q[slice_lo(g, DATA_W) +: DATA_W])
            );
        end
    end

    // Write-accept strobes, one cycle after the accepting edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_strobe_r <= '0;
        end else begin
            wr_strobe_r <= wr_sel_s;
        end
    end

    // Read pipeline: data captured with the request, held until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_r      <= '0;
            readdatavalid_r <= 1'b0;
        end else begin
            readdatavalid_r <= rd_req_s;
            if (rd_req_s) begin
                readdata_r <= rd_data_s;
            end else begin
                readdata_r <= readdata_r;
            end
        end
    end

    assign wr_strobe         = wr_strobe_r;
    assign bus.readdata      = readdata_r;
    assign bus.readdatavalid = readdatavalid_r;

    // ro_in of RW slots and hw_d/hw_we of RO slots are intentionally dead.
    assign unused_s = ^{ro_in, hw_d, hw_we};

endmodule

// File: tb/tb_avalon_reg_bank.sv
// Directed self-checking bench for avalon_reg_bank (defaults, RO_MASK = 8'h80).
module tb_avalon_reg_bank;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    logic                        clock;
    logic                        reset;
    logic [NUM_REGS*DATA_W-1:0]  reg_q;
    logic [NUM_REGS*DATA_W-1:0]  ro_in;
    logic [NUM_REGS-1:0]         hw_we;
    logic [NUM_REGS*DATA_W-1:0]  hw_d;
    logic [NUM_REGS-1:0]         wr_strobe;

    int n_total;
    int n_bad;

    avalon_reg_bank_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    avalon_reg_bank #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .ADDR_W    (ADDR_W),
        .RO_MASK   (8'h80),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .reg_q     (reg_q),
        .ro_in     (ro_in),
        .hw_we     (hw_we),
        .hw_d      (hw_d),
        .wr_strobe (wr_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return reg_q[i*DATA_W +: DATA_W];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.address    = 3'd0;
        bus.byteenable = 4'h0;
        bus.writedata  = 32'h0000_0000;
        hw_we          = 8'h00;
    endtask

    task automatic set_rd(input logic [2:0] a);
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        bus.address    = a;
    endtask

    task automatic set_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        bus.address    = a;
        bus.writedata  = d;
        bus.byteenable = be;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        ro_in   = '0;
        hw_d    = '0;
        idle();

        // 1: reset state and first read
        reset = 1'b1;
        step();
        step();
        for (int i = 0; i < NUM_REGS; i++) check("rst_regq", reg_of(i), 32'h0000_0000);
        check("rst_valid", {31'd0, bus.readdatavalid}, 32'd0);
        check("rst_rdata", bus.readdata, 32'h0000_0000);
        check("rst_strobe", {24'd0, wr_strobe}, 32'd0);
        reset = 1'b0;
        set_rd(3'd0);
        step();
        check("rd0_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("rd0_data", bus.readdata, 32'h0000_0000);
        idle();
        step();
        check("rd0_pulse_end", {31'd0, bus.readdatavalid}, 32'd0);

        // 2: byte-enabled write
        set_wr(3'd2, 32'hDEAD_BEEF, 4'b0101);
        step();
        check("wr2_reg", reg_of(2), 32'h00AD_00EF);
        check("wr2_strobe", {24'd0, wr_strobe}, 32'h0000_0004);
        idle();
        set_rd(3'd2);
        step();
        check("wr2_strobe_end", {24'd0, wr_strobe}, 32'd0);
        check("rd2_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("rd2_data", bus.readdata, 32'h00AD_00EF);
        idle();
        step();
        check("rd2_hold_valid", {31'd0, bus.readdatavalid}, 32'd0);
        check("rd2_hold_data", bus.readdata, 32'h00AD_00EF);

        // 3: same-cycle read and write return the old value
        set_wr(3'd3, 32'h1111_1111, 4'hF);
        step();
        set_wr(3'd3, 32'h2222_2222, 4'hF);
        set_rd(3'd3);
        step();
        check("rw3_old", bus.readdata, 32'h1111_1111);
        check("rw3_reg", reg_of(3), 32'h2222_2222);
        check("rw3_strobe", {24'd0, wr_strobe}, 32'h0000_0008);
        idle();
        set_rd(3'd3);
        step();
        check("rw3_new", bus.readdata, 32'h2222_2222);
        idle();

        // zero byteenable still strobes but changes nothing
        set_wr(3'd4, 32'hFFFF_FFFF, 4'h0);
        step();
        check("be0_strobe", {24'd0, wr_strobe}, 32'h0000_0010);
        check("be0_reg", reg_of(4), 32'h0000_0000);
        idle();

        // 4: read-only register
        ro_in[7*DATA_W +: DATA_W] = 32'hCAFE_F00D;
        set_wr(3'd7, 32'hFFFF_FFFF, 4'hF);
        step();
        check("ro7_strobe", {24'd0, wr_strobe}, 32'd0);
        check("ro7_regq", reg_of(7), 32'h0000_0000);
        idle();
        set_rd(3'd7);
        step();
        check("ro7_rdata", bus.readdata, 32'hCAFE_F00D);
        idle();

        // 5: bus/hw collision, plus plain hw loads (RO load ignored)
        hw_we = 8'h02;
        hw_d[1*DATA_W +: DATA_W] = 32'hAAAA_AAAA;
        set_wr(3'd1, 32'h5555_5555, 4'b0011);
        step();
        check("col1_reg", reg_of(1), 32'hAAAA_5555);
        check("col1_strobe", {24'd0, wr_strobe}, 32'h0000_0002);
        idle();
        hw_we = 8'h81;
        hw_d[0*DATA_W +: DATA_W] = 32'h0BAD_F00D;
        hw_d[7*DATA_W +: DATA_W] = 32'h1234_5678;
        step();
        check("hw0_reg", reg_of(0), 32'h0BAD_F00D);
        check("hw7_ignored", reg_of(7), 32'h0000_0000);
        check("hw_no_strobe", {24'd0, wr_strobe}, 32'd0);
        idle();

        // write without chipselect is ignored
        bus.write      = 1'b1;
        bus.address    = 3'd0;
        bus.writedata  = 32'hFFFF_FFFF;
        bus.byteenable = 4'hF;
        step();
        check("nocs_reg", reg_of(0), 32'h0BAD_F00D);
        check("nocs_strobe", {24'd0, wr_strobe}, 32'd0);
        idle();

        // 6: back-to-back reads, then reset drops an in-flight read
        set_rd(3'd0);
        step();
        check("b2b0_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b0_data", bus.readdata, 32'h0BAD_F00D);
        set_rd(3'd1);
        step();
        check("b2b1_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b1_data", bus.readdata, 32'hAAAA_5555);
        set_rd(3'd2);
        step();
        check("b2b2_valid", {31'd0, bus.readdatavalid}, 32'd1);
        check("b2b2_data", bus.readdata, 32'h00AD_00EF);
        set_rd(3'd3);
        reset = 1'b1;
        step();
        check("rstrd_valid", {31'd0, bus.readdatavalid}, 32'd0);
        check("rstrd_data", bus.readdata, 32'h0000_0000);
        check("rstrd_reg3", reg_of(3), 32'h0000_0000);
        idle();
        reset = 1'b0;
        step();
        check("rstrd_after", {31'd0, bus.readdatavalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
